// File: rtl/vend_output_sequencer.sv
// Vending output sequencer: queues pour/change requests and drives the water valve and coin
// hoppers one action at a time. Define VEND_SEQ_TIMEOUT_EN to enable the hopper-jam timeout.
module vend_output_sequencer #(
    parameter int POUR_LEN    = 200,
    parameter int PULSE_LEN   = 8,
    parameter int GAP_LEN     = 4,
    parameter int TIMEOUT_LEN = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic pour_req,
    input  logic chg1_req,
    input  logic chg2_req,
    input  logic chg22_req,
    input  logic coin_seen,
    output logic valve_open,
    output logic eject1,
    output logic eject2,
    output logic busy,
    output logic overflow,
    output logic fault
);

    localparam int T_A   = (POUR_LEN > PULSE_LEN) ? POUR_LEN : PULSE_LEN;
    localparam int T_B   = (GAP_LEN > TIMEOUT_LEN) ? GAP_LEN : TIMEOUT_LEN;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] POUR_LOAD    = TW'(POUR_LEN - 1);
    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POUR      = 3'd1,
        EJECT     = 3'd2,
        WAIT_COIN = 3'd3,
        GAP       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [1:0]    coins_r;
    logic          coin_two_r;
    logic          coin_flag_r;
    logic          valve_r;
    logic          eject1_r;
    logic          eject2_r;
    logic          busy_r;
    logic          overflow_r;

    // Request/grant vectors are indexed by priority: 0 pour, 1 chg22, 2 chg2, 3 chg1.
    logic [3:0] req_s;
    logic [3:0] grant_s;
    logic [1:0] cnt_r [4];

    assign req_s = {chg1_req, chg2_req, chg22_req, pour_req};

    assign valve_open = valve_r;
    assign eject1     = eject1_r;
    assign eject2     = eject2_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

`ifdef VEND_SEQ_TIMEOUT_EN
    logic fault_r;
    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    // Fixed-priority grant, only offered while the sequencer is idle.
    always_comb begin
        grant_s = 4'b0000;
        if (state_r == IDLE) begin
            if (cnt_r[0] != 2'd0) begin
                grant_s = 4'b0001;
            end else if (cnt_r[1] != 2'd0) begin
                grant_s = 4'b0010;
            end else if (cnt_r[2] != 2'd0) begin
                grant_s = 4'b0100;
            end else if (cnt_r[3] != 2'd0) begin
                grant_s = 4'b1000;
            end else begin
                grant_s = 4'b0000;
            end
        end else begin
            grant_s = 4'b0000;
        end
    end

    // Pending-request counters; a request hitting a full counter is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 2'd0;
            end
            overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({req_s[i], grant_s[i]})
                    2'b10: begin
                        if (cnt_r[i] == 2'd3) begin
                            overflow_r <= 1'b1;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + 2'd1;
                        end
                    end
                    2'b01:   cnt_r[i] <= cnt_r[i] - 2'd1;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Sequencer FSM; actuator and status outputs are registered with the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            timer_r     <= '0;
            coins_r     <= 2'd0;
            coin_two_r  <= 1'b0;
            coin_flag_r <= 1'b0;
            valve_r     <= 1'b0;
            eject1_r    <= 1'b0;
            eject2_r    <= 1'b0;
            busy_r      <= 1'b0;
`ifdef VEND_SEQ_TIMEOUT_EN
            fault_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s[0]) begin
                        state_r <= POUR;
                        timer_r <= POUR_LOAD;
                        coins_r <= 2'd0;
                        valve_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else if (grant_s[1] | grant_s[2] | grant_s[3]) begin
                        state_r     <= EJECT;
                        timer_r     <= PULSE_LOAD;
                        coins_r     <= grant_s[1] ? 2'd2 : 2'd1;
                        coin_two_r  <= ~grant_s[3];
                        coin_flag_r <= 1'b0;
                        eject1_r    <= grant_s[3];
                        eject2_r    <= ~grant_s[3];
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                POUR: begin
                    if (timer_r == '0) begin
                        state_r <= GAP;
                        timer_r <= GAP_LOAD;
                        valve_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                EJECT: begin
                    if (coin_seen) begin
                        coin_flag_r <= 1'b1;
                    end
                    if (timer_r == '0) begin
                        state_r  <= WAIT_COIN;
                        timer_r  <= TIMEOUT_LOAD;
                        eject1_r <= 1'b0;
                        eject2_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                WAIT_COIN: begin
                    // A coin seen during the strobe counts as soon as the strobe ends.
                    if (coin_flag_r | coin_seen) begin
                        state_r     <= GAP;
                        timer_r     <= GAP_LOAD;
                        coin_flag_r <= 1'b0;
                        coins_r     <= coins_r - 2'd1;
`ifdef VEND_SEQ_TIMEOUT_EN
                    end else if (timer_r == '0) begin
                        state_r <= FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
`else
                    end else begin
                        timer_r <= timer_r;
                    end
`endif
                end
                GAP: begin
                    if (timer_r == '0) begin
                        if (coins_r != 2'd0) begin
                            state_r  <= EJECT;
                            timer_r  <= PULSE_LOAD;
                            eject1_r <= ~coin_two_r;
                            eject2_r <= coin_two_r;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                FAULT: begin
                    state_r  <= FAULT;
                    valve_r  <= 1'b0;
                    eject1_r <= 1'b0;
                    eject2_r <= 1'b0;
                    busy_r   <= 1'b1;
                end
                default: begin
                    state_r  <= IDLE;
                    valve_r  <= 1'b0;
                    eject1_r <= 1'b0;
                    eject2_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule
